pcs_receive_mc: RTL and testbench

Multi-channel, parametrised 1000BASE-X PCS receive block. Each of CH independent lanes takes already-decoded code-groups (SUDI), tracks the Clause 36 receive state (idle/carrier/packet/end), and drives GMII-style rxd/rx_dv/rx_er. Per-lane saturating statistics counters track good packets, false carriers and in-packet errors. It sits between the per-lane synchronization/decoder stage and the GMII/MAC side, replacing the single-lane receive block.

---
 rtl/pcs_rx_pkg.sv | 23 ++
 rtl/pcs_rx_lane.sv | 120 ++++++++++++
 rtl/pcs_receive_mc.sv | 38 +++
 tb/tb_pcs_receive_mc.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pcs_rx_pkg.sv
// pcs_rx_pkg: code-group constants, receive state enum and SUDI field indices for the PCS receive path
// Ports: none (package)
package pcs_rx_pkg;
  localparam int SUDI_W = 11;
  localparam int CG_ERR = 10;
  localparam int IS_K = 9;
  localparam int RX_EVEN = 8;
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K_S = 8'hFB;
  localparam logic [7:0] K_T = 8'hFD;
  localparam logic [7:0] K_R = 8'hF7;
  localparam logic [7:0] K_V = 8'hFE;
  localparam logic [7:0] D_IDLE_1 = 8'hC5;
  localparam logic [7:0] D_IDLE_2 = 8'h50;
  localparam logic [7:0] RXD_PREAMBLE = 8'h55;
  localparam logic [7:0] RXD_FALSE_CARRIER = 8'h0E;
  typedef enum logic [2:0] {
    LINK_FAILED, WAIT_FOR_K, RX_K, IDLE_D, FALSE_CARRIER, RECEIVE, END_WAIT
  } state_t;
  function automatic logic is_k_sym(input logic [SUDI_W-1:0] s, input logic [7:0] code);
    return !s[CG_ERR] && s[IS_K] && s[7:0] == code;
  endfunction
endpackage

// File: rtl/pcs_rx_lane.sv
// pcs_rx_lane: one receive lane - state machine, GMII output stage and saturating statistics counters
// Ports: rx_clk/mr_main_reset (async active-low) clock and reset; sync_status, sudi, cnt_clr inputs;
//        rxd/rx_dv/rx_er GMII outputs; pkt_cnt/fc_cnt/err_cnt statistics
module pcs_rx_lane
  import pcs_rx_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int REG_OUT = 0
) (
  input  logic              rx_clk,
  input  logic              mr_main_reset,
  input  logic              sync_status,
  input  logic [SUDI_W-1:0] sudi,
  input  logic              cnt_clr,
  output logic [7:0]        rxd,
  output logic              rx_dv,
  output logic              rx_er,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  fc_cnt,
  output logic [CNT_W-1:0]  err_cnt
);
  state_t state;
  logic [7:0] data, d_rxd;
  logic d_dv, d_er, bad;
  logic k28, sym_s, sym_t, sym_r, valid_d, idle_d;
  logic inc_pkt, inc_fc, inc_err;
  assign data = sudi[7:0];
  assign k28 = is_k_sym(sudi, K28_5);
  assign sym_s = is_k_sym(sudi, K_S);
  assign sym_t = is_k_sym(sudi, K_T);
  assign sym_r = is_k_sym(sudi, K_R);
  assign valid_d = !sudi[CG_ERR] && !sudi[IS_K];
  assign idle_d = valid_d && (data == D_IDLE_1 || data == D_IDLE_2);
  // Counter events mirror the FSM transitions; a lost sync aborts the symbol without counting.
  assign inc_fc = sync_status && state == IDLE_D && !k28 && !sym_s;
  assign inc_pkt = sync_status && state == RECEIVE && sym_t && !bad;
  assign inc_err = sync_status && state == RECEIVE && !valid_d && !sym_t;
  always_ff @(posedge rx_clk or negedge mr_main_reset)
    if (!mr_main_reset) begin
      state <= LINK_FAILED;
      bad <= 1'b0;
      d_rxd <= '0;
      d_dv <= 1'b0;
      d_er <= 1'b0;
    end else begin
      d_rxd <= '0;
      d_dv <= 1'b0;
      d_er <= 1'b0;
      if (!sync_status) state <= LINK_FAILED;
      else
        case (state)
          LINK_FAILED: state <= WAIT_FOR_K;
          WAIT_FOR_K: if (k28 && sudi[RX_EVEN]) state <= RX_K;
          RX_K: state <= idle_d ? IDLE_D : WAIT_FOR_K;
          IDLE_D:
            if (k28) state <= RX_K;
            else if (sym_s) begin
              state <= RECEIVE;
              bad <= 1'b0;
              d_rxd <= RXD_PREAMBLE;
              d_dv <= 1'b1;
            end else begin
              state <= FALSE_CARRIER;
              d_rxd <= RXD_FALSE_CARRIER;
              d_er <= 1'b1;
            end
          FALSE_CARRIER:
            if (k28) state <= RX_K;
            else begin
              d_rxd <= RXD_FALSE_CARRIER;
              d_er <= 1'b1;
            end
          RECEIVE:
            if (sym_t) state <= END_WAIT;
            else if (k28) begin
              state <= RX_K;
              d_er <= 1'b1;
            end else begin
              d_rxd <= data;
              d_dv <= 1'b1;
              if (!valid_d) begin
                d_er <= 1'b1;
                bad <= 1'b1;
              end
            end
          END_WAIT: if (!sym_r) state <= k28 ? RX_K : WAIT_FOR_K;
          default: state <= LINK_FAILED;
        endcase
    end
  always_ff @(posedge rx_clk or negedge mr_main_reset)
    if (!mr_main_reset) begin
      pkt_cnt <= '0;
      fc_cnt <= '0;
      err_cnt <= '0;
    end else if (cnt_clr) begin
      pkt_cnt <= '0;
      fc_cnt <= '0;
      err_cnt <= '0;
    end else begin
      pkt_cnt <= pkt_cnt + CNT_W'(inc_pkt && pkt_cnt != '1);
      fc_cnt <= fc_cnt + CNT_W'(inc_fc && fc_cnt != '1);
      err_cnt <= err_cnt + CNT_W'(inc_err && err_cnt != '1);
    end
  if (REG_OUT != 0) begin : g_reg
    always_ff @(posedge rx_clk or negedge mr_main_reset)
      if (!mr_main_reset) begin
        rxd <= '0;
        rx_dv <= 1'b0;
        rx_er <= 1'b0;
      end else begin
        rxd <= d_rxd;
        rx_dv <= d_dv;
        rx_er <= d_er;
      end
  end else begin : g_direct
    assign rxd = d_rxd;
    assign rx_dv = d_dv;
    assign rx_er = d_er;
  end
endmodule

// File: rtl/pcs_receive_mc.sv
// pcs_receive_mc: multi-lane 1000BASE-X PCS receive block, CH independent lanes
// Ports: rx_clk/mr_main_reset (async active-low) clock and reset; sync_status[CH], sudi[CH*11], cnt_clr;
//        rxd[CH*8], rx_dv[CH], rx_er[CH]; pkt_cnt/fc_cnt/err_cnt [CH*CNT_W]
module pcs_receive_mc
  import pcs_rx_pkg::*;
#(
  parameter int CH = 4,
  parameter int CNT_W = 16,
  parameter int REG_OUT = 0
) (
  input  logic                 rx_clk,
  input  logic                 mr_main_reset,
  input  logic [CH-1:0]        sync_status,
  input  logic [CH*SUDI_W-1:0] sudi,
  input  logic                 cnt_clr,
  output logic [CH*8-1:0]      rxd,
  output logic [CH-1:0]        rx_dv,
  output logic [CH-1:0]        rx_er,
  output logic [CH*CNT_W-1:0]  pkt_cnt,
  output logic [CH*CNT_W-1:0]  fc_cnt,
  output logic [CH*CNT_W-1:0]  err_cnt
);
  for (genvar i = 0; i < CH; i++) begin : g_lane
    pcs_rx_lane #(.CNT_W(CNT_W), .REG_OUT(REG_OUT)) u_lane (
      .rx_clk(rx_clk),
      .mr_main_reset(mr_main_reset),
      .sync_status(sync_status[i]),
      .sudi(sudi[i*SUDI_W +: SUDI_W]),
      .cnt_clr(cnt_clr),
      .rxd(rxd[i*8 +: 8]),
      .rx_dv(rx_dv[i]),
      .rx_er(rx_er[i]),
      .pkt_cnt(pkt_cnt[i*CNT_W +: CNT_W]),
      .fc_cnt(fc_cnt[i*CNT_W +: CNT_W]),
      .err_cnt(err_cnt[i*CNT_W +: CNT_W])
    );
  end
endmodule

// File: tb/tb_pcs_receive_mc.sv
// tb_pcs_receive_mc: randomized check of pcs_receive_mc against a symbol-level receive model
module tb_pcs_receive_mc;
  localparam int CH = 4;
  localparam int WA = 3;
  localparam int WB = 2;
  localparam int M_LF = 0, M_WK = 1, M_RK = 2, M_ID = 3, M_FC = 4, M_RX = 5, M_EW = 6;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic [CH-1:0] sync = '0;
  logic [CH*11-1:0] sudi = '0;
  logic [CH*8-1:0] rxd_a, rxd_b;
  logic [CH-1:0] dv_a, er_a, dv_b, er_b;
  logic [CH*WA-1:0] pc_a, fc_a, ec_a;
  logic [CH*WB-1:0] pc_b, fc_b, ec_b;
  int checks = 0;
  int errors = 0;
  int mode[CH];
  bit bad[CH];
  int n_pkt[CH], n_fc[CH], n_err[CH];
  logic [9:0] out_now[CH], out_prev[CH];
  bit ph = 1'b0;
  always #5 clk = ~clk;
  pcs_receive_mc #(.CH(CH), .CNT_W(WA), .REG_OUT(0)) dut_a (
    .rx_clk(clk), .mr_main_reset(rst_n), .sync_status(sync), .sudi(sudi), .cnt_clr(clr),
    .rxd(rxd_a), .rx_dv(dv_a), .rx_er(er_a), .pkt_cnt(pc_a), .fc_cnt(fc_a), .err_cnt(ec_a));
  pcs_receive_mc #(.CH(CH), .CNT_W(WB), .REG_OUT(1)) dut_b (
    .rx_clk(clk), .mr_main_reset(rst_n), .sync_status(sync), .sudi(sudi), .cnt_clr(clr),
    .rxd(rxd_b), .rx_dv(dv_b), .rx_er(er_b), .pkt_cnt(pc_b), .fc_cnt(fc_b), .err_cnt(ec_b));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [10:0] kc(input logic [7:0] b);
    return {3'b011, b};
  endfunction
  function automatic logic [10:0] dc(input logic [7:0] b);
    return {3'b000, b};
  endfunction
  function automatic int sat(input int n, input int w);
    int m;
    m = (1 << w) - 1;
    return n > m ? m : n;
  endfunction
  task automatic model_reset();
    for (int l = 0; l < CH; l++) begin
      mode[l] = M_LF;
      bad[l] = 1'b0;
      n_pkt[l] = 0;
      n_fc[l] = 0;
      n_err[l] = 0;
      out_now[l] = '0;
      out_prev[l] = '0;
    end
  endtask
  // out = {er, dv, rxd}
  task automatic model_step(input int l, input bit s, input logic [10:0] sym, input bit c);
    bit ce, k, k28, ss, tt, rr, dd, idle;
    logic [7:0] d;
    logic [9:0] o;
    int ip, ifc, ie;
    ce = sym[10];
    k = sym[9];
    d = sym[7:0];
    k28 = !ce && k && d == 8'hBC;
    ss = !ce && k && d == 8'hFB;
    tt = !ce && k && d == 8'hFD;
    rr = !ce && k && d == 8'hF7;
    dd = !ce && !k;
    idle = dd && (d == 8'hC5 || d == 8'h50);
    o = '0;
    ip = 0;
    ifc = 0;
    ie = 0;
    out_prev[l] = out_now[l];
    if (!s) mode[l] = M_LF;
    else
      case (mode[l])
        M_LF: mode[l] = M_WK;
        M_WK: if (k28 && sym[8]) mode[l] = M_RK;
        M_RK: mode[l] = idle ? M_ID : M_WK;
        M_ID:
          if (k28) mode[l] = M_RK;
          else if (ss) begin mode[l] = M_RX; bad[l] = 1'b0; o = {2'b01, 8'h55}; end
          else begin mode[l] = M_FC; o = {2'b10, 8'h0E}; ifc = 1; end
        M_FC: if (k28) mode[l] = M_RK; else o = {2'b10, 8'h0E};
        M_RX:
          if (tt) begin mode[l] = M_EW; ip = bad[l] ? 0 : 1; end
          else if (k28) begin mode[l] = M_RK; o = {2'b10, 8'h00}; ie = 1; end
          else if (dd) o = {2'b01, d};
          else begin o = {2'b11, d}; ie = 1; bad[l] = 1'b1; end
        M_EW: if (!rr) mode[l] = k28 ? M_RK : M_WK;
        default: mode[l] = M_LF;
      endcase
    out_now[l] = o;
    if (c) begin
      n_pkt[l] = 0;
      n_fc[l] = 0;
      n_err[l] = 0;
    end else begin
      n_pkt[l] += ip;
      n_fc[l] += ifc;
      n_err[l] += ie;
    end
  endtask
  task automatic check_all();
    for (int l = 0; l < CH; l++) begin
      check($sformatf("rxd_a[%0d]", l), rxd_a[l*8 +: 8], out_now[l][7:0]);
      check($sformatf("dv_a[%0d]", l), dv_a[l], out_now[l][8]);
      check($sformatf("er_a[%0d]", l), er_a[l], out_now[l][9]);
      check($sformatf("rxd_b[%0d]", l), rxd_b[l*8 +: 8], out_prev[l][7:0]);
      check($sformatf("dv_b[%0d]", l), dv_b[l], out_prev[l][8]);
      check($sformatf("er_b[%0d]", l), er_b[l], out_prev[l][9]);
      check($sformatf("pkt_a[%0d]", l), pc_a[l*WA +: WA], sat(n_pkt[l], WA));
      check($sformatf("fc_a[%0d]", l), fc_a[l*WA +: WA], sat(n_fc[l], WA));
      check($sformatf("err_a[%0d]", l), ec_a[l*WA +: WA], sat(n_err[l], WA));
      check($sformatf("pkt_b[%0d]", l), pc_b[l*WB +: WB], sat(n_pkt[l], WB));
      check($sformatf("fc_b[%0d]", l), fc_b[l*WB +: WB], sat(n_fc[l], WB));
      check($sformatf("err_b[%0d]", l), ec_b[l*WB +: WB], sat(n_err[l], WB));
    end
  endtask
  task automatic cycle(input logic [CH-1:0] s, input logic [CH*11-1:0] sy, input bit c);
    @(negedge clk);
    sync = s;
    sudi = sy;
    clr = c;
    for (int l = 0; l < CH; l++) model_step(l, s[l], sy[l*11 +: 11], c);
    @(posedge clk);
    #1;
    check_all();
  endtask
  task automatic lane0(input logic [10:0] sym, input bit c);
    logic [CH*11-1:0] v;
    for (int l = 1; l < CH; l++) v[l*11 +: 11] = ph ? dc(8'hC5) : kc(8'hBC);
    v[10:0] = sym;
    cycle('1, v, c);
    ph = ~ph;
  endtask
  task automatic good_pkt(input bit clr_on_t);
    lane0(kc(8'hFB), 0);
    lane0(dc(8'h11), 0);
    lane0(dc(8'h22), 0);
    lane0(dc(8'h33), 0);
    lane0(kc(8'hFD), clr_on_t);
    lane0(kc(8'hF7), 0);
    lane0(kc(8'hBC), 0);
    lane0(dc(8'hC5), 0);
  endtask
  function automatic logic [10:0] rand_sym(input int l);
    int r;
    r = $urandom_range(0, 99);
    if (mode[l] == M_RX) begin
      if (r < 80) return dc(8'($urandom_range(0, 255)));
      if (r < 90) return kc(8'hFD);
      if (r < 93) return kc(8'hBC);
      if (r < 95) return kc(8'hFE);
      if (r < 97) return {1'b1, 10'($urandom)};
      return kc(8'($urandom));
    end
    if (r < 30) return {2'b01, 1'(r >= 2), 8'hBC};
    if (r < 55) return dc(r[0] ? 8'hC5 : 8'h50);
    if (r < 68) return kc(8'hFB);
    if (r < 78) return dc(8'($urandom_range(0, 255)));
    if (r < 84) return kc(8'hFD);
    if (r < 90) return kc(8'hF7);
    if (r < 93) return kc(8'hFE);
    if (r < 96) return {1'b1, 10'($urandom)};
    return kc(8'($urandom));
  endfunction
  initial begin
    logic [CH-1:0] s;
    logic [CH*11-1:0] v;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    check("reset_dv", {28'd0, dv_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) lane0(ph ? dc(8'hC5) : kc(8'hBC), 0);
    lane0(kc(8'hFB), 0);
    check("preamble", rxd_a[7:0], 8'h55);
    lane0(dc(8'h11), 0);
    lane0(dc(8'h22), 0);
    lane0(dc(8'h33), 0);
    lane0(kc(8'hFD), 0);
    check("dv_after_t", dv_a[0], 1'b0);
    lane0(kc(8'hF7), 0);
    lane0(kc(8'hBC), 0);
    lane0(dc(8'hC5), 0);
    check("pkt_one", pc_a[0 +: WA], 3'd1);
    lane0(kc(8'hFB), 0);
    lane0(dc(8'h11), 0);
    lane0(dc(8'h22) | 11'h400, 0);
    check("cg_err_er", er_a[0], 1'b1);
    lane0(kc(8'hFD), 0);
    lane0(kc(8'hBC), 0);
    lane0(dc(8'h50), 0);
    check("bad_pkt_cnt", pc_a[0 +: WA], 3'd1);
    check("bad_err_cnt", ec_a[0 +: WA], 3'd1);
    lane0(dc(8'h00), 0);
    check("fc_rxd", rxd_a[7:0], 8'h0E);
    lane0(dc(8'h33), 0);
    lane0(kc(8'hBC), 0);
    lane0(dc(8'hC5), 0);
    check("fc_cnt", fc_a[0 +: WA], 3'd1);
    lane0(kc(8'hFB), 0);
    lane0(dc(8'h44), 0);
    lane0(kc(8'hBC), 0);
    check("early_end_er", {dv_a[0], er_a[0]}, 2'b01);
    lane0(dc(8'hC5), 0);
    for (int i = 0; i < 5; i++) good_pkt(0);
    check("sat_b", pc_b[0 +: WB], 2'd3);
    check("sat_a", pc_a[0 +: WA], 3'd6);
    good_pkt(1);
    check("clr_vs_t", pc_a[0 +: WA], 3'd0);
    for (int i = 0; i < 2500; i++) begin
      if (i == 1200) begin
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_rxd", rxd_a, 32'd0);
        check("async_rst_cnt", pc_a, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
      for (int l = 0; l < CH; l++) begin
        s[l] = $urandom_range(0, 199) >= 3;
        v[l*11 +: 11] = rand_sym(l);
      end
      cycle(s, v, $urandom_range(0, 299) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
